// File: rtl/ariane_pkg.sv
// Shared core constants consumed by the D$ flush unit.
// Only the data-cache geometry is needed here.
package ariane_pkg;

    localparam int unsigned DCACHE_NUM_SETS     = 256;
    localparam int unsigned DCACHE_SET_ASSOC    = 8;
    localparam int unsigned DCACHE_TAG_WIDTH    = 44;
    localparam int unsigned DCACHE_OFFSET_WIDTH = 4;

endpackage

// File: rtl/dirty_way_sel.sv
// Lowest-set-bit priority encoder over a per-way mask.
// Ports: mask (per-way request bits), way (index of lowest set bit),
//        empty (no bit set; way is then 0).
module dirty_way_sel #(
    parameter int unsigned NR_WAYS = 8,
    parameter int unsigned WAY_W   = $clog2(NR_WAYS)
) (
    input  logic [NR_WAYS-1:0] mask,
    output logic [WAY_W-1:0]   way,
    output logic               empty
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        way   = '0;
        empty = ~|mask;
        for (int i = int'(NR_WAYS) - 1; i >= 0; i--) begin
            if (mask[i]) begin
                way = WAY_W'(i);
            end
        end
    end

endmodule

// File: rtl/dcache_flush_unit.sv
// Walks every D$ set, writes back valid+dirty lines, then invalidates the set.
// Ports: clk_i/rst_i (sync active-high), flush_i/flush_ack_o handshake,
//        busy_o, miss_busy_i, tag port (req/we/index, valid/dirty/rdata),
//        writeback port (wb_valid_o/wb_ready_i, wb_addr_o, wb_way_o).
module dcache_flush_unit
    import ariane_pkg::*;
#(
    parameter int unsigned    NR_SETS  = DCACHE_NUM_SETS,
    parameter int unsigned    NR_WAYS  = DCACHE_SET_ASSOC,
    parameter int unsigned    TAG_W    = DCACHE_TAG_WIDTH,
    parameter int unsigned    OFFSET_W = DCACHE_OFFSET_WIDTH,
    localparam int unsigned   INDEX_W  = $clog2(NR_SETS),
    localparam int unsigned   WAY_W    = $clog2(NR_WAYS),
    localparam int unsigned   ADDR_W   = TAG_W + INDEX_W + OFFSET_W
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    output logic                     flush_ack_o,
    output logic                     busy_o,
    input  logic                     miss_busy_i,
    output logic                     tag_req_o,
    output logic                     tag_we_o,
    output logic [INDEX_W-1:0]       tag_index_o,
    input  logic [NR_WAYS-1:0]       tag_valid_i,
    input  logic [NR_WAYS-1:0]       tag_dirty_i,
    input  logic [NR_WAYS*TAG_W-1:0] tag_rdata_i,
    output logic                     wb_valid_o,
    input  logic                     wb_ready_i,
    output logic [ADDR_W-1:0]        wb_addr_o,
    output logic [WAY_W-1:0]         wb_way_o
);

    typedef enum logic [2:0] {
        IDLE, DRAIN, READ, INSPECT, WB, CLEAR, ACK, WAIT_LOW
    } state_e;

    state_e               state_q, state_d;
    logic [INDEX_W-1:0]   index_q, index_d;
    logic [NR_WAYS-1:0]   pending_q, pending_d;
    logic [TAG_W-1:0]     tags_q [NR_WAYS];
    logic                 load_tags;
    logic [WAY_W-1:0]     sel_way;
    logic                 sel_empty;

    dirty_way_sel #(
        .NR_WAYS (NR_WAYS),
        .WAY_W   (WAY_W)
    ) u_dirty_way_sel (
        .mask  (pending_q),
        .way   (sel_way),
        .empty (sel_empty)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            index_q   <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            pending_q <= pending_d;
        end
    end

    // Tags only matter while pending bits exist, so they need no reset.
    always_ff @(posedge clk_i) begin
        if (load_tags) begin
            for (int i = 0; i < int'(NR_WAYS); i++) begin
                tags_q[i] <= tag_rdata_i[i*TAG_W +: TAG_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        pending_d   = pending_q;
        load_tags   = 1'b0;
        flush_ack_o = 1'b0;
        tag_req_o   = 1'b0;
        tag_we_o    = 1'b0;
        tag_index_o = '0;
        wb_valid_o  = 1'b0;
        wb_addr_o   = '0;
        wb_way_o    = '0;
        busy_o      = (state_q != IDLE) && (state_q != WAIT_LOW);

        unique case (state_q)
            IDLE: begin
                if (flush_i) begin
                    index_d = '0;
                    state_d = miss_busy_i ? DRAIN : READ;
                end
            end
            DRAIN: begin
                if (!miss_busy_i) begin
                    index_d = '0;
                    state_d = READ;
                end
            end
            READ: begin
                tag_req_o   = 1'b1;
                tag_index_o = index_q;
                state_d     = INSPECT;
            end
            INSPECT: begin
                // Invalid lines never write back, whatever their dirty bit.
                pending_d = tag_valid_i & tag_dirty_i;
                load_tags = 1'b1;
                state_d   = (|pending_d) ? WB : CLEAR;
            end
            WB: begin
                if (sel_empty) begin
                    state_d = CLEAR;
                end else begin
                    wb_valid_o = 1'b1;
                    wb_way_o   = sel_way;
                    wb_addr_o  = {tags_q[sel_way], index_q,
                                  {OFFSET_W{1'b0}}};
                    if (wb_ready_i) begin
                        pending_d = pending_q
                                  & ~(NR_WAYS'(1) << sel_way);
                        if (pending_d == '0) begin
                            state_d = CLEAR;
                        end
                    end
                end
            end
            CLEAR: begin
                tag_we_o    = 1'b1;
                tag_index_o = index_q;
                if (index_q == INDEX_W'(NR_SETS - 1)) begin
                    state_d = ACK;
                end else begin
                    index_d = index_q + 1'b1;
                    state_d = READ;
                end
            end
            ACK: begin
                flush_ack_o = 1'b1;
                state_d     = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!flush_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dcache_flush_unit.sv
// Scoreboard bench for dcache_flush_unit with a tag-RAM emulator,
// a writeback responder and a set/way reference model.
module tb_dcache_flush_unit;

    localparam int NS      = 4;
    localparam int NW      = 2;
    localparam int TW      = 12;
    localparam int OW      = 4;
    localparam int IW      = 2;
    localparam int WW      = 1;
    localparam int AW      = TW + IW + OW;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [WW-1:0] way;
    } wb_t;

    logic             clk = 1'b0;
    logic             rst_i = 1'b1;
    logic             flush_i = 1'b0;
    logic             flush_ack_o;
    logic             busy_o;
    logic             miss_busy_i = 1'b0;
    logic             tag_req_o;
    logic             tag_we_o;
    logic [IW-1:0]    tag_index_o;
    logic [NW-1:0]    tag_valid_i = '0;
    logic [NW-1:0]    tag_dirty_i = '0;
    logic [NW*TW-1:0] tag_rdata_i = '0;
    logic             wb_valid_o;
    logic             wb_ready_i = 1'b0;
    logic [AW-1:0]    wb_addr_o;
    logic [WW-1:0]    wb_way_o;

    dcache_flush_unit #(
        .NR_SETS  (NS),
        .NR_WAYS  (NW),
        .TAG_W    (TW),
        .OFFSET_W (OW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .flush_ack_o (flush_ack_o),
        .busy_o      (busy_o),
        .miss_busy_i (miss_busy_i),
        .tag_req_o   (tag_req_o),
        .tag_we_o    (tag_we_o),
        .tag_index_o (tag_index_o),
        .tag_valid_i (tag_valid_i),
        .tag_dirty_i (tag_dirty_i),
        .tag_rdata_i (tag_rdata_i),
        .wb_valid_o  (wb_valid_o),
        .wb_ready_i  (wb_ready_i),
        .wb_addr_o   (wb_addr_o),
        .wb_way_o    (wb_way_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    function automatic void chk(string nm, logic [63:0] act,
                                logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     nm, act, exp, $time);
        end
    endfunction

    // Cache contents model
    bit            mv [NS][NW];
    bit            md [NS][NW];
    logic [TW-1:0] mt [NS][NW];

    // Tag RAM emulator: read data one cycle after request.
    always @(posedge clk) begin
        if (tag_req_o) begin
            for (int w = 0; w < NW; w++) begin
                tag_valid_i[w]            <= mv[tag_index_o][w];
                tag_dirty_i[w]            <= md[tag_index_o][w];
                tag_rdata_i[w*TW +: TW]   <= mt[tag_index_o][w];
            end
        end
        if (tag_we_o) begin
            for (int w = 0; w < NW; w++) begin
                mv[tag_index_o][w] = 1'b0;
                md[tag_index_o][w] = 1'b0;
            end
        end
    end

    // Scoreboard state
    wb_t  wb_q[$];
    int   req_q[$];
    int   we_q[$];
    int   stall_q[$];
    int   edges = 0;
    int   start_edge = 0;
    int   exp_first = 0;
    int   exp_ack_cyc = 0;
    bit   active = 1'b0;
    bit   first_pending = 1'b0;
    bit   ack_seen = 1'b0;
    int   ack_count = 0;
    bit   mon_hold = 1'b0;
    bit   resp_have = 1'b0;
    int   resp_cur = 0;

    always @(posedge clk) edges <= edges + 1;

    // Writeback responder: each line gets a planned number of stall cycles.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (wb_valid_o) begin
                if (!resp_have) begin
                    resp_cur  = (stall_q.size() > 0) ? stall_q.pop_front() : 0;
                    resp_have = 1'b1;
                end
                if (resp_cur > 0) begin
                    wb_ready_i = 1'b0;
                    resp_cur--;
                end else begin
                    wb_ready_i = 1'b1;
                    resp_have  = 1'b0;
                end
            end else begin
                wb_ready_i = 1'b0;
            end
        end
    end

    // Monitor
    bit            prev_stall = 1'b0;
    logic [AW-1:0] prev_addr;
    logic [WW-1:0] prev_way;

    always @(negedge clk) begin
        int  cyc;
        int  nact;
        wb_t e;
        cyc = edges - start_edge;
        if (mon_hold) begin
            prev_stall = 1'b0;
        end else begin
            nact = int'(tag_req_o) + int'(tag_we_o) + int'(wb_valid_o);
            chk("exclusive", 64'(nact <= 1), 64'd1);
            chk("busy", 64'(busy_o),
                64'(active && cyc >= 1 && cyc <= exp_ack_cyc));
            if (prev_stall) begin
                chk("wb_stable", {wb_valid_o, wb_addr_o, wb_way_o},
                    {1'b1, prev_addr, prev_way});
            end
            prev_stall = wb_valid_o && !wb_ready_i;
            prev_addr  = wb_addr_o;
            prev_way   = wb_way_o;
            if (tag_req_o) begin
                chk("req_active", 64'(active), 64'd1);
                if (first_pending) begin
                    chk("first_req_cycle", 64'(cyc), 64'(exp_first));
                    first_pending = 1'b0;
                end
                chk("req_expected", 64'(req_q.size() > 0), 64'd1);
                if (req_q.size() > 0)
                    chk("req_index", 64'(tag_index_o), 64'(req_q.pop_front()));
            end
            if (tag_we_o) begin
                chk("we_expected", 64'(we_q.size() > 0), 64'd1);
                if (we_q.size() > 0)
                    chk("we_index", 64'(tag_index_o), 64'(we_q.pop_front()));
            end
            if (wb_valid_o && wb_ready_i) begin
                chk("wb_expected", 64'(wb_q.size() > 0), 64'd1);
                if (wb_q.size() > 0) begin
                    e = wb_q.pop_front();
                    chk("wb_addr", 64'(wb_addr_o), 64'(e.addr));
                    chk("wb_way", 64'(wb_way_o), 64'(e.way));
                end
            end
            if (flush_ack_o) begin
                ack_count++;
                chk("ack_expected", 64'(active), 64'd1);
                if (active) chk("ack_cycle", 64'(cyc), 64'(exp_ack_cyc));
                active   = 1'b0;
                ack_seen = 1'b1;
            end
        end
    end

    task automatic clear_cache();
        for (int s = 0; s < NS; s++)
            for (int w = 0; w < NW; w++) begin
                mv[s][w] = 1'b0;
                md[s][w] = 1'b0;
                mt[s][w] = '0;
            end
    endtask

    task automatic fill_random();
        for (int s = 0; s < NS; s++)
            for (int w = 0; w < NW; w++) begin
                mv[s][w] = 1'($urandom_range(0, 1));
                md[s][w] = 1'($urandom_range(0, 1));
                mt[s][w] = TW'($urandom_range(0, 4095));
            end
    endtask

    // Reference model: sets in order, ways low to high; each dirty line
    // costs one cycle plus its stalls, each set three cycles.
    task automatic start_flush(input int drain, input int stall_mode);
        int extra;
        int st;
        wb_t e;
        extra = 0;
        for (int s = 0; s < NS; s++) begin
            req_q.push_back(s);
            we_q.push_back(s);
            for (int w = 0; w < NW; w++) begin
                if (mv[s][w] && md[s][w]) begin
                    e.addr = (AW'(mt[s][w]) << (IW + OW)) | (AW'(s) << OW);
                    e.way  = WW'(w);
                    wb_q.push_back(e);
                    st = (stall_mode < 0) ? $urandom_range(0, 3) : stall_mode;
                    stall_q.push_back(st);
                    extra += 1 + st;
                end
            end
        end
        exp_first     = (drain == 0) ? 1 : drain + 1;
        exp_ack_cyc   = exp_first + 3 * NS + extra;
        start_edge    = edges;
        ack_seen      = 1'b0;
        first_pending = 1'b1;
        active        = 1'b1;
        flush_i       = 1'b1;
        miss_busy_i   = (drain > 0);
    endtask

    task automatic run_flush(input int drain, input int stall_mode,
                             input int hold);
        start_flush(drain, stall_mode);
        for (int c = 1; c <= 400 && !ack_seen; c++) begin
            @(negedge clk);
            if (c == drain) miss_busy_i = 1'b0;
        end
        chk("ack_seen", 64'(ack_seen), 64'd1);
        chk("wb_left", 64'(wb_q.size()), 64'd0);
        chk("we_left", 64'(we_q.size()), 64'd0);
        chk("req_left", 64'(req_q.size()), 64'd0);
        repeat (hold) @(negedge clk);
        flush_i     = 1'b0;
        miss_busy_i = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int acks_before;
        bit seen;
        clear_cache();
        rst_i    = 1'b1;
        mon_hold = 1'b1;
        @(negedge clk);
        chk("reset_outs", {flush_ack_o, busy_o, tag_req_o, tag_we_o,
                           tag_index_o, wb_valid_o, wb_addr_o, wb_way_o}, '0);
        @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        mon_hold = 1'b0;
        @(negedge clk);

        // Clean cache
        run_flush(0, 0, 1);

        // One dirty line, plus an invalid-but-dirty line that must be skipped
        clear_cache();
        mv[2][1] = 1'b1;
        md[2][1] = 1'b1;
        mt[2][1] = 12'h01A;
        md[3][0] = 1'b1;
        run_flush(0, 0, 1);

        // Same line with a five-cycle writeback stall
        clear_cache();
        mv[2][1] = 1'b1;
        md[2][1] = 1'b1;
        mt[2][1] = 12'h01A;
        run_flush(0, 5, 1);

        // Miss handler busy for three cycles
        fill_random();
        run_flush(3, -1, 1);

        // Held request after ack, then drop and re-raise
        fill_random();
        run_flush(0, -1, 10);
        fill_random();
        run_flush(0, -1, 0);

        // Randomized flushes
        for (int i = 0; i < 8; i++) begin
            fill_random();
            run_flush($urandom_range(0, 3), -1, $urandom_range(0, 3));
        end

        // Reset while a writeback is pending
        clear_cache();
        mv[1][0] = 1'b1;
        md[1][0] = 1'b1;
        mt[1][0] = 12'h03C;
        start_flush(0, 8);
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            seen = wb_valid_o;
        end
        chk("rst_wb_seen", 64'(seen), 64'd1);
        mon_hold = 1'b1;
        rst_i    = 1'b1;
        flush_i  = 1'b0;
        @(negedge clk);
        chk("rst_mid_outs", {flush_ack_o, busy_o, tag_req_o, tag_we_o,
                             tag_index_o, wb_valid_o, wb_addr_o, wb_way_o}, '0);
        rst_i     = 1'b0;
        active    = 1'b0;
        wb_q.delete();
        req_q.delete();
        we_q.delete();
        stall_q.delete();
        resp_have = 1'b0;
        resp_cur  = 0;
        first_pending = 1'b0;
        acks_before = ack_count;
        @(negedge clk);
        mon_hold = 1'b0;
        repeat (30) @(negedge clk);
        chk("no_ack_after_rst", 64'(ack_count), 64'(acks_before));

        // Normal flush after abandoned one
        fill_random();
        run_flush(0, -1, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
